load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of ALU_reg in the RV32I core. It consumes the ALU's read_address/write_address (the effective addresses) and the rs2 value for stores. It runs a handshaked access on the data bus and returns aligned, sign- or zero-extended load data to the register-file write path. While an access is outstanding it stalls the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS without bus_ack before the access aborts with bus_error
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  7  current instruction opcode
funct3  in  3  access size/sign
read_address  in  32  load effective address (ALU)
write_address  in  32  store effective address (ALU)
store_data  in  32  rs2 value (regALU2)
bus_rdata  in  32  bus read data, valid with bus_ack
bus_ack  in  1  bus completion strobe
bus_read  out  1  read request
bus_write  out  1  write request
bus_addr  out  32  word-aligned bus address
bus_wdata  out  32  lane-replicated write data
bus_sel  out  4  byte enables
load_data  out  32  formatted load result, to reg_write
stall  out  1  freeze PC/IF
done  out  1  one-cycle completion pulse
bus_error  out  1  timeout or illegal funct3, valid with done
misaligned  out  1  misaligned-access flag, valid with done

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, counter 0, bus strobes drop immediately. Reset mid-access abandons the transfer; there is no retry.
- Load opcode 0000011: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Store opcode 0100011: SB 000, SH 001, SW 010. Any other funct3 is illegal.
- Address select: load uses read_address; store uses write_address. off = addr[1:0].
- IDLE:
  - Memory op with legal funct3 → ACCESS. Latch bus_addr={addr[31:2],2'b00}, bus_sel, bus_wdata, size and sign.
  - Illegal funct3 → DONE with bus_error=1.
  - stall = 1 combinationally whenever a memory op is present in IDLE.
- ACCESS:
  - bus_read or bus_write held high, with latched fields stable, until bus_ack.
  - On bus_ack at an edge: capture formatted load_data (loads only) → DONE.
  - Counter increments each cycle. At count == TIMEOUT_CYCLES-1 with no ack: → DONE, bus_error=1, load_data=0.
  - stall=1.
- DONE (exactly one cycle):
  - done=1, stall=0, strobes 0; PC advances at this edge → IDLE.
  - load_data, bus_error and misaligned hold until the next access starts.
- Latency: with zero-wait ack, stall is high 2 cycles (IDLE-detect, ACCESS) and done rises on cycle 3. Each extra wait cycle adds one.
- bus_sel:
  - Byte: 4'b0001<<off.
  - Half: 4'b0011<<{off[1],1'b0}.
  - Word: 4'b1111.
- bus_wdata:
  - Byte: {4{sd[7:0]}}.
  - Half: {2{sd[15:0]}}.
  - Word: sd.
- Load format: rdata>>(8*off), then byte/half sign-extend (LB/LH) or zero-extend (LBU/LHU); word passes through.
- bus_ack outside ACCESS is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a half with off[0]=1 or a word with off≠0 goes IDLE→DONE with no bus access, misaligned=1, load_data=0.
- Undefined: misaligned is tied 0 and offending low address bits are ignored (half uses off[1] only, word uses off=0).

Decomposition:
- Shared package rv32i_pkg: OPC_LOAD/OPC_STORE constants, funct3 size enum, lsu_state_t {IDLE, ACCESS, DONE}.
- Sub-module lsu_lane_align (combinational): produces bus_sel and bus_wdata, and formats load data.
- FSM and timeout counter stay in load_store_unit.

Test Plan:
1. Bus model word 0x80C17F05 @0x100, zero-wait ack. LB 0x103 → load_data 0xFFFFFF80; LBU 0x103 → 0x00000080; done one pulse on cycle 3.
2. Same word. LH 0x102 → 0xFFFF80C1; LHU 0x100 → 0x00007F05; LW 0x100 → 0x80C17F05.
3. SB store_data 0x123456AB, addr 0x101 → bus_write=1, bus_addr 0x100, bus_sel 4'b0010, bus_wdata 0xABABABAB. SH 0x102 → sel 4'b1100, wdata 0x56AB56AB.
4. Ack delayed 3 cycles → stall high 5 consecutive cycles, bus signals stable throughout, single done pulse, bus_error=0. No ack for 16 cycles → done with bus_error=1, load_data 0.
5. rst pulled low during ACCESS → bus_read drops immediately, stall/done 0; after release the same instruction restarts cleanly from IDLE.
6. LW 0x102: with LSU_MISALIGN_TRAP_EN → no bus strobe, done with misaligned=1. Without it → bus_addr 0x100, sel 4'b1111, load_data 0x80C17F05.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: opcodes, access sizes, LSU states
// and small decode helpers used by load_store_unit and lsu_lane_align.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Access size is carried in funct3[1:0]; funct3[2] selects zero-extension.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } lsu_state_t;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Byte offset actually used for the access: halves drop bit 0, words use 0.
  function automatic logic [1:0] eff_off(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: byte enables and replicated write data
// for an outgoing request, and shift/extend of returned read data.
module lsu_lane_align
  import rv32i_pkg::*;
(
  input  lsu_size_t   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  input  lsu_size_t   ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Request side: byte enables and lane-replicated store data.
  always_comb begin
    sel   = 4'b1111;
    wdata = store_data;
    case (req_size)
      SZ_BYTE: begin
        sel   = 4'b0001 << req_off;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        sel   = 4'b0011 << {req_off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        sel   = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Response side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = rdata >> {ld_off, 3'b000};
    load_data = shifted;
    case (ld_size)
      SZ_BYTE: load_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: runs one handshaked data-bus access per memory
// instruction, stalls the core while it is outstanding and returns
// formatted load data. Optional build macro LSU_MISALIGN_TRAP_EN makes
// misaligned halves/words complete immediately with misaligned=1 and no
// bus access; without it the low offending address bits are ignored.
//
//   state  | meaning
//   IDLE   | waiting for a load/store opcode
//   ACCESS | bus strobe held until bus_ack or timeout
//   DONE   | one-cycle completion, done=1, core released
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        bus_error,
  output logic        misaligned
);

  lsu_state_t  state;
  logic [CNT_W-1:0] cnt;
  lsu_size_t   ld_size;
  logic        ld_unsigned;
  logic [1:0]  ld_off;
  logic        acc_is_load;

  logic        is_load, is_store, mem_op, legal, mis_req;
  logic [31:0] addr;
  lsu_size_t   req_size;
  logic [1:0]  req_off;
  logic [3:0]  sel_req;
  logic [31:0] wdata_req;
  logic [31:0] fmt_data;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign mem_op   = is_load | is_store;
  assign addr     = is_store ? write_address : read_address;
  assign req_size = lsu_size_t'(funct3[1:0]);
  assign req_off  = eff_off(req_size, addr[1:0]);
  assign legal    = funct3_legal(is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_req = is_misaligned(req_size, addr[1:0]);
`else
  assign mis_req = 1'b0;
`endif

  // Stall is combinational so the core freezes in the cycle the op is seen.
  assign stall = rst & (((state == IDLE) & mem_op) | (state == ACCESS));

  lsu_lane_align u_align (
    .req_size    (req_size),
    .req_off     (req_off),
    .store_data  (store_data),
    .sel         (sel_req),
    .wdata       (wdata_req),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ld_off      (ld_off),
    .rdata       (bus_rdata),
    .load_data   (fmt_data)
  );

  // Access FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_size     <= SZ_BYTE;
      ld_unsigned <= 1'b0;
      ld_off      <= 2'b00;
      acc_is_load <= 1'b0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_sel     <= '0;
      load_data   <= '0;
      done        <= 1'b0;
      bus_error   <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (!legal) begin
              state      <= DONE;
              done       <= 1'b1;
              bus_error  <= 1'b1;
              misaligned <= 1'b0;
              load_data  <= '0;
            end else if (mis_req) begin
              state      <= DONE;
              done       <= 1'b1;
              bus_error  <= 1'b0;
              misaligned <= 1'b1;
              load_data  <= '0;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              bus_read    <= is_load;
              bus_write   <= is_store;
              bus_addr    <= {addr[31:2], 2'b00};
              bus_sel     <= sel_req;
              bus_wdata   <= wdata_req;
              ld_size     <= req_size;
              ld_unsigned <= funct3[2];
              ld_off      <= req_off;
              acc_is_load <= is_load;
              load_data   <= '0;
              bus_error   <= 1'b0;
              misaligned  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            if (acc_is_load) load_data <= fmt_data;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_error <= 1'b1;
            load_data <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
